instr_queue_reg: RTL
====================

# instr_queue_reg

Parametrised instruction register with a small prefetch queue, the next generation of the SAP-1 instruction register. It accepts instruction words from RAM via the bus, splits the head instruction into opcode (to the controller) and operand (to the bus), and buffers up to DEPTH instructions so fetch can run ahead of execution. It sits between the W-bus, the controller/sequencer and RAM, with a synchronous reset.

## Interface

Parameters:
- WORD_W, 8, instruction word width
- OPC_W, 4, opcode width (upper bits); operand width is WORD_W-OPC_W
- DEPTH, 4, queue entries; power of two, >= 2

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- data_in  in  WORD_W  instruction word from bus
- instr_in  in  1  push data_in into queue
- instr_out  in  1  drive head operand onto bus
- advance  in  1  controller retires head instruction (pop)
- flush  in  1  empty the queue (present only with IR_FLUSH_EN)
- data_out_controller  out  OPC_W  head opcode
- opc_valid  out  1  head opcode valid (queue non-empty)
- data_out_bus  out  WORD_W-OPC_W  operand to bus, registered
- count  out  $clog2(DEPTH+1)  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: push attempted while full without pop

## Operation

- Storage: DEPTH x WORD_W circular buffer, write pointer, read pointer, count register; pointers wrap modulo DEPTH.
- Push: instr_in & (!full | advance) writes data_in at write pointer, write pointer +1.
- Pop: advance & !empty increments read pointer; advance on empty ignored, no state change.
- Simultaneous push+pop: count unchanged, both pointers advance; legal when full (new word takes freed slot) and when empty only as a push (pop ignored, count becomes 1).
- Push while full without advance: word dropped, no pointer/count change, overflow set to 1 and held until reset (or flush).
- data_out_controller = head word [WORD_W-1 -: OPC_W] when !empty, else 0. opc_valid = !empty. Both derived from registered state only.
- data_out_bus: on edge with instr_out & !empty, loads head operand [WORD_W-OPC_W-1:0]; on any other edge loads 0 (bus-OR friendly, never holds stale operand). instr_out and advance in same cycle: operand sampled from pre-pop head.
- Reset (rst_n=0 at edge): pointers, count, overflow, data_out_bus all 0; empty=1, full=0, opc_valid=0, data_out_controller=0. Reset overrides all other inputs, including mid-push/pop. Buffer contents need not be cleared.

## Timing

- Push-to-head latency: 1 cycle (word written at edge N visible on data_out_controller after edge N when queue was empty).
- Pop: new head visible after the same edge.
- instr_out-to-bus latency: 1 cycle; operand valid for exactly one cycle per instr_out cycle.
- full/empty/count/overflow update on the same edge as the causing event.
- Priority per edge: rst_n > flush > push/pop.

## Configuration

- IR_FLUSH_EN defined: flush port exists; flush=1 at edge clears pointers, count, overflow and data_out_bus, ignoring instr_in/advance/instr_out that cycle (used on jumps).
- IR_FLUSH_EN undefined: no flush port; queue only drains via advance; overflow clears only on reset.

## Test plan

- Reset: hold rst_n=0 with instr_in=1, data_in=8'hA5 -> after edge count=0, empty=1, opc_valid=0, data_out_bus=0.
- Push 8'h1E then instr_out=1 one cycle -> data_out_controller=4'h1, opc_valid=1; next cycle data_out_bus=4'hE, following cycle 0.
- Push 8'h11,8'h22,8'h33,8'h44 (DEPTH=4) then 8'h55 -> full=1, count=4, overflow=1, head opcode 4'h1; pop 4 times -> opcodes 1,2,3,4 in order, 8'h55 never appears, empty=1.
- Full queue, push 8'h66 with advance=1 -> count stays 4, overflow stays 0, later drains 2,3,4,6 (wrap-around exercised).
- advance on empty -> count 0, pointers unchanged; subsequent push 8'h7C -> opcode 4'h7.
- IR_FLUSH_EN: 3 entries queued, flush=1 with instr_in=1 -> count=0, empty=1, overflow=0, pushed word discarded.

Source files
------------

// File: rtl/instr_queue_reg_if.sv
// instr_queue_reg_if: handshake/bus bundle for the instruction prefetch queue.
// The flush signal exists only when IR_FLUSH_EN is defined.
interface instr_queue_reg_if #(
    parameter int WORD_W = 8,
    parameter int OPC_W  = 4,
    parameter int DEPTH  = 4
) ();
    logic [WORD_W-1:0]          data_in;
    logic                       instr_in;
    logic                       instr_out;
    logic                       advance;
`ifdef IR_FLUSH_EN
    logic                       flush;
`endif
    logic [OPC_W-1:0]           data_out_controller;
    logic                       opc_valid;
    logic [WORD_W-OPC_W-1:0]    data_out_bus;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       full;
    logic                       empty;
    logic                       overflow;

    // Bus/controller side: drives requests, observes queue state.
    modport master (
`ifdef IR_FLUSH_EN
        output flush,
`endif
        output data_in, instr_in, instr_out, advance,
        input  data_out_controller, opc_valid, data_out_bus,
        input  count, full, empty, overflow
    );

    // Queue side.
    modport slave (
`ifdef IR_FLUSH_EN
        input  flush,
`endif
        input  data_in, instr_in, instr_out, advance,
        output data_out_controller, opc_valid, data_out_bus,
        output count, full, empty, overflow
    );
endinterface

// File: rtl/instr_queue_reg.sv
// instr_queue_reg: instruction register with a DEPTH-entry prefetch queue.
// Head word is split into opcode (to controller) and operand (to bus).
// Optional macro IR_FLUSH_EN adds a synchronous flush input (used on jumps).
module instr_queue_reg #(
    parameter int WORD_W = 8,
    parameter int OPC_W  = 4,
    parameter int DEPTH  = 4
) (
    input logic               clk,
    input logic               rst_n,
    instr_queue_reg_if.slave  q_if
);
    localparam int OPR_W = WORD_W - OPC_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic [OPR_W-1:0]  r_bus;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic [WORD_W-1:0] w_head;

`ifdef IR_FLUSH_EN
    assign w_flush = q_if.flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // A pop on an empty queue is ignored; a push into a full queue is only
    // accepted when the head retires in the same cycle and frees its slot.
    assign w_pop   = q_if.advance & ~w_empty;
    assign w_push  = q_if.instr_in & (~w_full | q_if.advance);
    assign w_head  = r_mem[r_rd_ptr];

    // Buffer write; contents are not cleared on reset, pointers guard validity.
    always_ff @(posedge clk) begin
        if (rst_n && !w_flush && w_push) begin
            r_mem[r_wr_ptr] <= q_if.data_in;
        end
    end

    // Pointer, occupancy, sticky overflow and registered operand update.
    always_ff @(posedge clk) begin
        if (!rst_n || w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_bus      <= '0;
        end else begin
            // Operand is taken from the pre-pop head; zero otherwise so the
            // bus can be wire-ORed with other drivers.
            r_bus <= (q_if.instr_out && !w_empty) ? w_head[OPR_W-1:0] : '0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (q_if.instr_in && w_full && !q_if.advance) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign q_if.data_out_controller = w_empty ? '0 : w_head[WORD_W-1 -: OPC_W];
    assign q_if.opc_valid           = ~w_empty;
    assign q_if.data_out_bus        = r_bus;
    assign q_if.count               = r_count;
    assign q_if.full                = w_full;
    assign q_if.empty               = w_empty;
    assign q_if.overflow            = r_overflow;

endmodule
